// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from an incoming VGA hsync/vsync pair, tracks
// timing lock against the nominal frame geometry and counts lock losses.
module vga_sync_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LEN  = 10'(H_TOTAL);
  localparam logic [9:0] V_LEN  = 10'(V_TOTAL);
  localparam logic [9:0] H_LOAD = 10'(H_SYNC_START);
  localparam logic [9:0] V_LOAD = 10'(V_SYNC_START);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] SAT    = 10'd1023;

  state_t     state, state_nxt;
  logic       hs_prev, vs_prev;
  logic [9:0] lc, fc;
  logic       bad_line;

  logic       hs_fall, vs_fall, bad_len, leave_lock;
  logic [9:0] len_now, x_nxt, y_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hs_fall = pix_en & hs_prev & ~hsync;
    vs_fall = pix_en & vs_prev & ~vsync;
    len_now = (lc == SAT) ? SAT : lc + 10'd1;
    bad_len = hs_fall && (len_now != H_LEN);
    x_nxt   = x;
    y_nxt   = y;
    if (pix_en) begin
      if (hs_fall)          x_nxt = H_LOAD;
      else if (x == H_LAST) x_nxt = '0;
      else                  x_nxt = x + 10'd1;
      // A resync load of x is not a wrap, so only a free-running wrap advances y.
      if (vs_fall)                        y_nxt = V_LOAD;
      else if (!hs_fall && x == H_LAST)   y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_fall) state_nxt = ACQUIRE;
      ACQUIRE: if (vs_fall && fc == V_LEN && !bad_line && !bad_len) state_nxt = LOCKED;
      LOCKED:  if (bad_len || (vs_fall && fc != V_LEN)) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    leave_lock = (state == LOCKED) && (state_nxt == SEARCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      x           <= '0;
      y           <= '0;
      lc          <= '0;
      fc          <= '0;
      bad_line    <= 1'b0;
      line_len    <= '0;
      err_cnt     <= '0;
      locked      <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      locked      <= (state_nxt == LOCKED);
      active      <= (state_nxt == LOCKED) && (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start <= pix_en && (state == LOCKED) && (state_nxt == LOCKED) &&
                     (x_nxt == '0) && (y_nxt == '0);
      if (leave_lock && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (pix_en) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
        x       <= x_nxt;
        y       <= y_nxt;
        if (hs_fall) begin
          lc       <= '0;
          line_len <= len_now;
        end else if (lc != SAT) begin
          lc <= lc + 10'd1;
        end
        // An hsync fall coincident with vsync belongs to the new frame.
        if (vs_fall)                   fc <= hs_fall ? 10'd1 : 10'd0;
        else if (hs_fall && fc != SAT) fc <= fc + 10'd1;
        if (vs_fall)      bad_line <= 1'b0;
        else if (bad_len) bad_line <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 12x6 frame geometry so
// lock, loss and saturation scenarios fit in a short run.
module tb_vga_sync_decoder;

  localparam int HT  = 12;
  localparam int VT  = 6;
  localparam int HSS = 8;
  localparam int VSS = 4;
  localparam int HA  = 6;
  localparam int VA  = 3;
  localparam int HW  = 2;

  logic       clk = 1'b0;
  logic       rst, pix_en, hsync, vsync;
  logic [9:0] x, y, line_len;
  logic       active, locked, frame_start;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit fast  = 1'b0;
  bit track = 1'b1;
  logic locked_q = 1'b0;
  int cur_x, cur_y;
  int drop_x = -1, drop_y = -1, drop_len = -1, rise_x = -1, rise_y = -1;
  int fs_cnt = 0, act_cnt = 0;
  int fs_pos_bad = 0, fs_idle_bad = 0, act_bad = 0, xy_bad = 0, hold_bad = 0, stall_bad = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_START(HSS), .V_SYNC_START(VSS),
    .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .active(active), .locked(locked), .frame_start(frame_start),
    .line_len(line_len), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic observe();
    if (locked_q && !locked) begin
      drop_x = cur_x; drop_y = cur_y; drop_len = int'(line_len);
    end
    if (!locked_q && locked) begin
      rise_x = cur_x; rise_y = cur_y;
    end
    locked_q = locked;
    if (frame_start) begin
      fs_cnt++;
      if (track && (cur_x != 0 || cur_y != 0)) fs_pos_bad++;
    end
    if (active) act_cnt++;
    if (track && locked) begin
      if (int'(x) != cur_x || int'(y) != cur_y) xy_bad++;
      if (active != (cur_x < HA && cur_y < VA)) act_bad++;
    end
  endtask

  // One generator pixel: a pix_en edge, then (slow mode) an idle edge.
  task automatic pix_cycle(input logic hs, input logic vs);
    logic [9:0] xs, ys, ls;
    logic [7:0] es;
    logic       as, lk;
    pix_en = 1'b1; hsync = hs; vsync = vs;
    @(negedge clk);
    observe();
    if (!fast) begin
      xs = x; ys = y; ls = line_len; es = err_cnt; as = active; lk = locked;
      pix_en = 1'b0;
      @(negedge clk);
      if (frame_start) fs_idle_bad++;
      if (x != xs || y != ys || line_len != ls || err_cnt != es || active != as || locked != lk)
        hold_bad++;
    end
  endtask

  task automatic run_seg(input int yy, input int x0, input int x1);
    for (int i = x0; i < x1; i++) begin
      cur_x = i; cur_y = yy;
      pix_cycle(!(i >= HSS && i < HSS + HW), !(yy == VSS));
    end
  endtask

  task automatic run_frame(input int nlines, input int short_y, input int short_len);
    fs_cnt = 0; act_cnt = 0;
    for (int yy = 0; yy < nlines; yy++) run_seg(yy, 0, (yy == short_y) ? short_len : HT);
  endtask

  task automatic do_reset(input logic sync_lvl);
    rst = 1'b1; pix_en = 1'b1; hsync = sync_lvl; vsync = sync_lvl;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    locked_q = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_x"}, int'(x), 0);
    check({pfx, "_y"}, int'(y), 0);
    check({pfx, "_active"}, int'(active), 0);
    check({pfx, "_locked"}, int'(locked), 0);
    check({pfx, "_frame_start"}, int'(frame_start), 0);
    check({pfx, "_line_len"}, int'(line_len), 0);
    check({pfx, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    @(negedge clk);

    // Reset with syncs held low: everything clears, no edge is recorded.
    do_reset(1'b0);
    check_all_zero("rst");
    cur_x = -1; cur_y = -1;
    pix_cycle(1'b1, 1'b1);
    check("post_rst_x_incr", int'(x), 1);
    check("post_rst_line_len", int'(line_len), 0);

    // Acquire: first vsync fall only acquires, second locks.
    run_frame(VT, -1, 0);
    check("lock_after_1st_vsync", int'(locked), 0);
    run_frame(VT, -1, 0);
    check("lock_after_2nd_vsync", int'(locked), 1);
    check("lock_rise_x", rise_x, 0);
    check("lock_rise_y", rise_y, VSS);
    check("line_len_clean", int'(line_len), HT);

    // Locked tracking over clean frames.
    for (int f = 0; f < 2; f++) begin
      run_frame(VT, -1, 0);
      check("frame_start_per_frame", fs_cnt, 1);
      check("active_per_frame", act_cnt, HA * VA);
    end
    check("xy_track", xy_bad, 0);
    check("active_track", act_bad, 0);
    check("frame_start_pos", fs_pos_bad, 0);
    check("end_frame_x", int'(x), HT - 1);
    check("end_frame_y", int'(y), VT - 1);

    // One short line while locked.
    track = 1'b0;
    run_frame(VT, 2, HT - 1);
    check("short_line_len", drop_len, HT - 1);
    check("short_line_drop_x", drop_x, HSS);
    check("short_line_drop_y", drop_y, 3);
    check("short_line_err_cnt", int'(err_cnt), 1);
    check("short_line_unlocked", int'(locked), 0);
    run_frame(VT, -1, 0);
    check("short_line_relock", int'(locked), 1);
    check("short_line_relock_y", rise_y, VSS);

    // A frame one line short: loss appears at the following vsync fall.
    run_frame(VT - 1, -1, 0);
    check("short_frame_still_locked", int'(locked), 1);
    run_frame(VT, -1, 0);
    check("short_frame_unlocked", int'(locked), 0);
    check("short_frame_drop_x", drop_x, 0);
    check("short_frame_drop_y", drop_y, VSS);
    check("short_frame_err_cnt", int'(err_cnt), 2);
    run_frame(VT, -1, 0);
    check("short_frame_acquire", int'(locked), 0);
    run_frame(VT, -1, 0);
    check("short_frame_relock", int'(locked), 1);
    track = 1'b1;

    // Reset mid-frame while locked.
    run_seg(0, 0, HT);
    run_seg(1, 0, HT);
    do_reset(1'b0);
    check_all_zero("midrst");
    for (int yy = 2; yy < VT; yy++) run_seg(yy, 0, HT);
    check("midrst_no_lock_1st_vsync", int'(locked), 0);
    run_frame(VT, -1, 0);
    check("midrst_lock_2nd_vsync", int'(locked), 1);
    check("midrst_err_cnt", int'(err_cnt), 0);

    // 50-clock pix_en stall mid-line with sync toggling that must be ignored.
    xy_bad = 0;
    run_seg(0, 0, HT);
    run_seg(1, 0, HT);
    run_seg(2, 0, 5);
    begin
      logic [9:0] xs, ys, ls;
      logic       as, lk;
      xs = x; ys = y; ls = line_len; as = active; lk = locked;
      pix_en = 1'b0;
      for (int i = 0; i < 50; i++) begin
        hsync = i[0]; vsync = i[1];
        @(negedge clk);
        if (x != xs || y != ys || line_len != ls || active != as || locked != lk || frame_start)
          stall_bad++;
      end
      hsync = 1'b1; vsync = 1'b1;
    end
    check("stall_frozen", stall_bad, 0);
    run_seg(2, 5, HT);
    for (int yy = 3; yy < VT; yy++) run_seg(yy, 0, HT);
    check("stall_xy_track", xy_bad, 0);
    check("stall_line_len", int'(line_len), HT);
    check("stall_locked", int'(locked), 1);
    check("idle_frame_start_low", fs_idle_bad, 0);
    check("idle_outputs_hold", hold_bad, 0);

    // Repeated lock losses saturate err_cnt.
    fast = 1'b1; track = 1'b0;
    for (int n = 0; n < 255; n++) begin
      run_frame(VT, 1, HT - 1);
      run_frame(VT, -1, 0);
    end
    check("err_cnt_255", int'(err_cnt), 255);
    check("relocked_after_losses", int'(locked), 1);
    for (int n = 0; n < 45; n++) begin
      run_frame(VT, 1, HT - 1);
      run_frame(VT, -1, 0);
    end
    check("err_cnt_saturated", int'(err_cnt), 255);

    // Overlong line: captured length saturates.
    for (int i = 0; i < 1200; i++) begin
      cur_x = i; cur_y = 0;
      pix_cycle(1'b1, 1'b1);
    end
    pix_cycle(1'b0, 1'b1);
    check("long_line_len", int'(line_len), 1023);
    check("long_line_unlocked", int'(locked), 0);
    check("long_line_err_cnt", int'(err_cnt), 255);

    pix_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
